// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the parametrised UART receiver.
//   - uart_state_e   : receiver FSM states
//   - PAR_* constants: parity mode encoding for the PARITY parameter
//   - cnt_width()    : bit-period counter width for a given BIT_CYCLES
//   - maj3()         : 3-input majority vote
//   - parity_mismatch(): parity check over a zero-extended data word
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } uart_state_e;

   localparam int PAR_NONE = 32'sd0;
   localparam int PAR_ODD  = 32'sd1;
   localparam int PAR_EVEN = 32'sd2;

   // Widest payload the receiver supports; parity is computed over this width.
   localparam int MAX_DATA_BITS = 32'sd9;

   function automatic int cnt_width(input int cycles);
      return (cycles < 32'sd2) ? 32'sd1 : $clog2(cycles);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Zero-extension of the data word does not change its XOR reduction.
   function automatic logic parity_mismatch(input logic [MAX_DATA_BITS-1:0] data,
                                            input logic                     par_bit,
                                            input logic                     odd);
      return ((^data) ^ par_bit) != odd;
   endfunction

endpackage

// File: rtl/uart_rx_sample.sv
// -----------------------------------------------------------------------------
// uart_rx_sample
//   Brings the asynchronous rx pin into the clk domain through a two-flop
//   synchroniser and produces the bit value the receiver samples.
//   Build option UART_RX_MAJ3_EN: vote is the majority of the last three
//   synchronised values (the caller samples one cycle later so the window is
//   centred on the nominal mid-bit). Otherwise vote equals rxs.
// Ports
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (synchroniser resets to idle-high)
//   rx    in  raw serial line
//   rxs   out synchronised line value
//   vote  out value to use at a sample point
// -----------------------------------------------------------------------------
module uart_rx_sample (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rxs,
   output logic vote
);

`ifdef UART_RX_MAJ3_EN
   localparam int DEPTH = 32'sd4;
`else
   localparam int DEPTH = 32'sd2;
`endif

   logic [DEPTH-1:0] sh_q;
   logic [DEPTH-1:0] sh_d;

   // Shift the raw pin into the synchroniser / tap chain.
   always_comb begin
      sh_d = {sh_q[DEPTH-2:0], rx};
   end

   // Synchroniser and tap registers, idle-high after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= {DEPTH{1'b1}};
      end else begin
         sh_q <= sh_d;
      end
   end

   assign rxs = sh_q[1];

`ifdef UART_RX_MAJ3_EN
   assign vote = uart_pkg::maj3(sh_q[1], sh_q[2], sh_q[3]);
`else
   assign vote = sh_q[1];
`endif

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver with valid/ready output handshake,
//   false-start rejection and parity / framing / overrun error reporting.
//   Build option UART_RX_MAJ3_EN: 3-tap majority sampling (one extra cycle
//   of latency); undefined: single sample at mid-bit.
// Parameters
//   BIT_CYCLES clk cycles per bit (8..65535)
//   DATA_BITS  payload bits, LSB first (5..9)
//   PARITY     PAR_NONE / PAR_ODD / PAR_EVEN
//   STOP_BITS  1 or 2, each one checked
// Ports
//   clk, rst_n  clock, async active-low reset
//   rx          serial input, idle high
//   rx_data     received word (valid with rx_valid)
//   rx_valid    word held until rx_valid & rx_ready
//   rx_ready    consumer accept
//   parity_err  parity mismatch of held word
//   frame_err   a stop bit of held word sampled low
//   overrun     1-cycle pulse when a completed word is dropped
//   busy        receiver not idle
// -----------------------------------------------------------------------------
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int BIT_CYCLES = 26,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W  = cnt_width(BIT_CYCLES);
   localparam int BITN_W = 32'sd4;
`ifdef UART_RX_MAJ3_EN
   // Majority window ends one cycle after mid-bit, so every sample slips by one.
   localparam int SAMPLE_LAG = 32'sd1;
`else
   localparam int SAMPLE_LAG = 32'sd0;
`endif
   localparam int START_PT = BIT_CYCLES / 2 + SAMPLE_LAG;

   logic rxs_s;
   logic bit_s;

   uart_rx_sample u_sample (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .rxs   (rxs_s),
      .vote  (bit_s)
   );

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BITN_W-1:0]    bitn_q, bitn_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_o_q, perr_o_d;
   logic                 ferr_o_q, ferr_o_d;
   logic                 overrun_q, overrun_d;
   logic                 busy_q, busy_d;

   logic                     complete_s;
   logic                     word_ferr_s;
   logic                     at_start_s;
   logic                     at_bit_s;
   logic [MAX_DATA_BITS-1:0] par_data_s;

   assign at_start_s = (cnt_q == CNT_W'(START_PT));
   assign at_bit_s   = (cnt_q == CNT_W'(BIT_CYCLES - 1));

   // Zero-extend the shifted payload for the parity helper.
   always_comb begin
      par_data_s                = {MAX_DATA_BITS{1'b0}};
      par_data_s[DATA_BITS-1:0] = shift_q;
   end

   // Receiver FSM: next state, bit timing, payload shift and error accumulation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      bitn_d      = bitn_q;
      shift_d     = shift_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      armed_d     = armed_q;
      complete_s  = 1'b0;
      word_ferr_s = ferr_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = {CNT_W{1'b0}};
            bitn_d = {BITN_W{1'b0}};
            // After a break the line must return high before a new start edge counts.
            if (!armed_q) begin
               armed_d = rxs_s;
            end else if (!rxs_s) begin
               state_d = ST_START;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (at_start_s) begin
               cnt_d   = {CNT_W{1'b0}};
               bitn_d  = {BITN_W{1'b0}};
               state_d = bit_s ? ST_IDLE : ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (at_bit_s) begin
               cnt_d   = {CNT_W{1'b0}};
               shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
               if (bitn_q == BITN_W'(DATA_BITS - 1)) begin
                  bitn_d  = {BITN_W{1'b0}};
                  state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
               end else begin
                  bitn_d = bitn_q + BITN_W'(1);
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PAR: begin
            if (at_bit_s) begin
               cnt_d   = {CNT_W{1'b0}};
               bitn_d  = {BITN_W{1'b0}};
               perr_d  = parity_mismatch(par_data_s, bit_s, PARITY == PAR_ODD);
               state_d = ST_STOP;
            end else begin
               state_d = ST_PAR;
            end
         end
         ST_STOP: begin
            if (at_bit_s) begin
               cnt_d       = {CNT_W{1'b0}};
               word_ferr_s = ferr_q | ~bit_s;
               ferr_d      = word_ferr_s;
               if (bitn_q == BITN_W'(STOP_BITS - 1)) begin
                  // Leave at the last stop mid-bit so back-to-back frames resync.
                  complete_s = 1'b1;
                  bitn_d     = {BITN_W{1'b0}};
                  armed_d    = bit_s;
                  state_d    = ST_IDLE;
               end else begin
                  bitn_d = bitn_q + BITN_W'(1);
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            bitn_d  = {BITN_W{1'b0}};
         end
      endcase
   end

   // Output register: hold until accepted, load or drop completed words.
   always_comb begin
      data_d    = data_q;
      perr_o_d  = perr_o_q;
      ferr_o_d  = ferr_o_q;
      overrun_d = 1'b0;
      busy_d    = (state_d != ST_IDLE);
      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      if (complete_s && (!valid_q || rx_ready)) begin
         valid_d  = 1'b1;
         data_d   = shift_q;
         perr_o_d = perr_q;
         ferr_o_d = word_ferr_s;
      end else if (complete_s) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         bitn_q    <= {BITN_W{1'b0}};
         shift_q   <= {DATA_BITS{1'b0}};
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         armed_q   <= 1'b1;
         data_q    <= {DATA_BITS{1'b0}};
         valid_q   <= 1'b0;
         perr_o_q  <= 1'b0;
         ferr_o_q  <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bitn_q    <= bitn_d;
         shift_q   <= shift_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         armed_q   <= armed_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_o_q  <= perr_o_d;
         ferr_o_q  <= ferr_o_d;
         overrun_q <= overrun_d;
         busy_q    <= busy_d;
      end
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign parity_err = perr_o_q;
   assign frame_err  = ferr_o_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//   Directed bench for uart_rx_param. Instance a is 8N1, instance b is 8E1.
//   Works with or without UART_RX_MAJ3_EN (timing checks allow the extra cycle).
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

   localparam int BITC = 26;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_a = 1'b1, rx_b = 1'b1;
   logic       ready_a = 1'b0, ready_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
   logic       ovr_a, ovr_b, busy_a, busy_b;

   int n_checks = 0;
   int n_fail   = 0;

   int         acc_a = 0, acc_b = 0, ovr_cnt_a = 0, ovr_cnt_b = 0;
   logic [7:0] acc_data_a = 8'd0, acc_data_b = 8'd0;
   logic       acc_perr_a = 1'b0, acc_ferr_a = 1'b0, acc_perr_b = 1'b0, acc_ferr_b = 1'b0;

   always #5 clk = ~clk;

   uart_rx_param #(.BIT_CYCLES(BITC), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
      .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
      .busy(busy_a));

   uart_rx_param #(.BIT_CYCLES(BITC), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
      .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
      .busy(busy_b));

   // Record accepted words and overrun pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (valid_a && ready_a) begin
         acc_a      <= acc_a + 1;
         acc_data_a <= data_a;
         acc_perr_a <= perr_a;
         acc_ferr_a <= ferr_a;
      end
      if (valid_b && ready_b) begin
         acc_b      <= acc_b + 1;
         acc_data_b <= data_b;
         acc_perr_b <= perr_b;
         acc_ferr_b <= ferr_b;
      end
      if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
      if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) rx_b = v;
      else rx_a = v;
   endtask

   // Drive n bits LSB first, one bit period each.
   task automatic send_bits(input bit sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         drive(sel, bits[i]);
         tick(BITC);
      end
      drive(sel, 1'b1);
   endtask

   task automatic send_8n1(input logic [7:0] d, input logic stop);
      send_bits(1'b0, {6'b111111, stop, d, 1'b0}, 10);
   endtask

   task automatic send_8p1(input logic [7:0] d, input logic par);
      send_bits(1'b1, {5'b11111, 1'b1, par, d, 1'b0}, 11);
   endtask

   initial begin
      int a0, o0, busy_wait;

      // Reset state
      tick(5);
      check("reset_valid", {31'd0, valid_a}, 32'd0);
      check("reset_data", {24'd0, data_a}, 32'd0);
      check("reset_busy", {31'd0, busy_a}, 32'd0);
      check("reset_flags", {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
      check("reset_b", {30'd0, valid_b, busy_b}, 32'd0);
      rst_n = 1'b1;
      tick(10);

      // 1. Plain 8N1 word accepted immediately
      ready_a = 1'b1;
      send_8n1(8'h55, 1'b1);
      tick(30);
      check("t1_count", acc_a, 32'd1);
      check("t1_data", {24'd0, acc_data_a}, 32'h55);
      check("t1_flags", {30'd0, acc_perr_a, acc_ferr_a}, 32'd0);
      check("t1_valid_drop", {31'd0, valid_a}, 32'd0);

      // 2. Even parity: wrong then right parity bit
      send_8p1(8'hA3, 1'b1);
      tick(30);
      check("t2_count_bad", acc_b, 32'd1);
      check("t2_data_bad", {24'd0, acc_data_b}, 32'hA3);
      check("t2_perr_bad", {31'd0, acc_perr_b}, 32'd1);
      send_8p1(8'hA3, 1'b0);
      tick(30);
      check("t2_count_good", acc_b, 32'd2);
      check("t2_perr_good", {30'd0, acc_perr_b, acc_ferr_b}, 32'd0);

      // 3. Stop bit low, then a clean frame
      send_8n1(8'h3C, 1'b0);
      tick(30);
      check("t3_count_bad", acc_a, 32'd2);
      check("t3_data_bad", {24'd0, acc_data_a}, 32'h3C);
      check("t3_ferr_bad", {31'd0, acc_ferr_a}, 32'd1);
      send_8n1(8'h81, 1'b1);
      tick(30);
      check("t3_count_good", acc_a, 32'd3);
      check("t3_data_good", {24'd0, acc_data_a}, 32'h81);
      check("t3_ferr_good", {31'd0, acc_ferr_a}, 32'd0);

      // 4. Five-cycle low glitch is a false start
      a0 = acc_a;
      rx_a = 1'b0;
      tick(5);
      rx_a = 1'b1;
      check("t4_busy_set", {31'd0, busy_a}, 32'd1);
      busy_wait = 0;
      while (busy_a && busy_wait < BITC) begin
         tick(1);
         busy_wait++;
      end
      check("t4_busy_clear", {31'd0, busy_a}, 32'd0);
      tick(40);
      check("t4_no_word", acc_a - a0, 32'd0);
      check("t4_valid", {31'd0, valid_a}, 32'd0);

      // 5. Overrun with consumer stalled, then one accept
      ready_a = 1'b0;
      a0 = acc_a;
      o0 = ovr_cnt_a;
      send_8n1(8'h11, 1'b1);
      send_8n1(8'h22, 1'b1);
      tick(30);
      check("t5_valid_held", {31'd0, valid_a}, 32'd1);
      check("t5_data_held", {24'd0, data_a}, 32'h11);
      check("t5_overrun", ovr_cnt_a - o0, 32'd1);
      check("t5_no_accept", acc_a - a0, 32'd0);
      ready_a = 1'b1;
      tick(5);
      check("t5_one_accept", acc_a - a0, 32'd1);
      check("t5_accept_data", {24'd0, acc_data_a}, 32'h11);
      check("t5_valid_drop", {31'd0, valid_a}, 32'd0);

      // 6. Reset during data bit 4 of 0xF0
      send_bits(1'b0, 16'h00E0, 5);   // start + data bits 0..3 of 0xF0 (all 0)
      rx_a = 1'b1;                    // data bit 4 of 0xF0
      tick(10);
      check("t6_busy_before", {31'd0, busy_a}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_outputs", {22'd0, data_a, valid_a, busy_a}, 32'd0);
      tick(3);
      rst_n = 1'b1;
      a0 = acc_a;
      tick(40);
      check("t6_no_partial", acc_a - a0, 32'd0);
      send_8n1(8'h0F, 1'b1);
      tick(30);
      check("t6_count", acc_a - a0, 32'd1);
      check("t6_data", {24'd0, acc_data_a}, 32'h0F);

      // Break: long low line yields one zero word with frame error
      a0 = acc_a;
      rx_a = 1'b0;
      tick(25 * BITC);
      check("brk_count", acc_a - a0, 32'd1);
      check("brk_word", {23'd0, acc_data_a, acc_ferr_a}, 32'd1);
      rx_a = 1'b1;
      tick(40);
      check("brk_idle", {30'd0, busy_a, valid_a}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
